// File: rtl/irq_coalesce_pkg.sv
// Shared types, defaults and helpers for the IRQ coalescing controller.
package irq_coalesce_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 6;
    localparam int unsigned TMO_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ASSERT = 2'd2
    } state_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/irq_pend_bank.sv
// Per-channel rising-edge detect and pending latch with write-1-to-clear ack.
module irq_pend_bank #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] evt,
    input  logic              ack_valid,
    input  logic [NUM_CH-1:0] ack_bits,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] evt_d;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr;
    logic              primed;

    // evt_d resets to 0, so the first edge after reset only captures the
    // current levels; a line already high at release is not a new event.
    assign rise = evt & ~evt_d & {NUM_CH{primed}};
    assign clr  = ack_bits & {NUM_CH{ack_valid}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_d   <= '0;
            primed  <= 1'b0;
            pending <= '0;
        end else begin
            evt_d   <= evt;
            primed  <= 1'b1;
            pending <= rise | (pending & ~clr);
        end
    end

endmodule

// File: rtl/irq_coalesce_ctrl.sv
// Coalescing IRQ controller: threshold/timeout FSM over unmasked pending bits.
// Define IRQ_PULSE_EN for pulsed irq with periodic re-pulse; default is level.
module irq_coalesce_ctrl
    import irq_coalesce_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned TMO_W  = TMO_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] evt,
    input  logic [NUM_CH-1:0] mask,
    input  logic              ack_valid,
    input  logic [NUM_CH-1:0] ack_bits,
    input  logic [CNT_W-1:0]  thresh,
    input  logic [TMO_W-1:0]  timeout,
    output logic [NUM_CH-1:0] pending,
    output logic              irq
);

    state_t             state, state_nx;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
    logic [CNT_W-1:0]   ucount, eff_th;
    logic [31:0]        unmasked;
    logic               tmo_hit;
    logic               irq_nx;

    irq_pend_bank #(
        .NUM_CH (NUM_CH)
    ) u_pend (
        .clk       (clk),
        .reset_n   (reset_n),
        .evt       (evt),
        .ack_valid (ack_valid),
        .ack_bits  (ack_bits),
        .pending   (pending)
    );

    always_comb begin
        unmasked             = '0;
        unmasked[NUM_CH-1:0] = pending & ~mask;
    end

    assign ucount  = CNT_W'(popcount(unmasked));
    assign eff_th  = (thresh == '0) ? CNT_W'(1) : thresh;
    assign tmo_hit = (timeout != '0) && (tmo_cnt == timeout - TMO_W'(1));

    always_comb begin
        state_nx = state;
        tmo_nx   = tmo_cnt;
        case (state)
            IDLE: begin
                if (ucount != '0) begin
                    state_nx = (ucount >= eff_th) ? ASSERT : WAIT;
                    tmo_nx   = '0;
                end
            end
            WAIT: begin
                if (ucount == '0) begin
                    state_nx = IDLE;
                end else if ((ucount >= eff_th) || tmo_hit) begin
                    state_nx = ASSERT;
                    tmo_nx   = '0;
                end else if (tmo_cnt != '1) begin
                    tmo_nx = tmo_cnt + TMO_W'(1);
                end
            end
            ASSERT: begin
                if (ucount == '0) begin
                    state_nx = IDLE;
`ifdef IRQ_PULSE_EN
                end else if (tmo_hit) begin
                    tmo_nx = '0;
                end else if (tmo_cnt != '1) begin
                    tmo_nx = tmo_cnt + TMO_W'(1);
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef IRQ_PULSE_EN
    assign irq_nx = ((state_nx == ASSERT) && (state != ASSERT)) ||
                    ((state == ASSERT) && (state_nx == ASSERT) && tmo_hit);
`else
    assign irq_nx = (state_nx == ASSERT);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            irq     <= 1'b0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_nx;
            irq     <= irq_nx;
        end
    end

endmodule

// File: tb/tb_irq_coalesce_ctrl.sv
// Directed self-checking bench for irq_coalesce_ctrl (level irq build).
module tb_irq_coalesce_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  evt;
    logic [3:0]  mask;
    logic        ack_valid;
    logic [3:0]  ack_bits;
    logic [5:0]  thresh;
    logic [15:0] timeout;
    logic [3:0]  pending;
    logic        irq;

    int unsigned checks;
    int unsigned failures;

    irq_coalesce_ctrl #(
        .NUM_CH (4),
        .CNT_W  (6),
        .TMO_W  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .evt       (evt),
        .mask      (mask),
        .ack_valid (ack_valid),
        .ack_bits  (ack_bits),
        .thresh    (thresh),
        .timeout   (timeout),
        .pending   (pending),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        evt       = 4'hF;
        mask      = 4'h0;
        ack_valid = 1'b0;
        ack_bits  = 4'h0;
        thresh    = 6'd1;
        timeout   = 16'd0;

        // reset with evt held high
        step(); step(); step();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        step(); step();
        chk("rel_pending", 32'(pending), 32'h0);
        chk("rel_irq", 32'(irq), 32'h0);

        // thresh=1: single event on ch2, then ack
        evt = 4'h0;
        step();
        evt = 4'b0100;
        step();
        chk("t1_pending", 32'(pending), 32'h4);
        chk("t1_irq_k", 32'(irq), 32'h0);
        step();
        chk("t1_irq_k1", 32'(irq), 32'h1);
        ack_valid = 1'b1; ack_bits = 4'b0100;
        step();
        ack_valid = 1'b0; ack_bits = 4'h0;
        chk("t1_ack_pending", 32'(pending), 32'h0);
        chk("t1_ack_irq_m", 32'(irq), 32'h1);
        step();
        chk("t1_ack_irq_m1", 32'(irq), 32'h0);

        // thresh=3 accumulation
        thresh = 6'd3;
        evt = 4'b0111;
        step();
        chk("t3_pend2", 32'(pending), 32'h3);
        step();
        chk("t3_irq_below", 32'(irq), 32'h0);
        evt = 4'b1111;
        step();
        chk("t3_pend3", 32'(pending), 32'hB);
        chk("t3_irq_k", 32'(irq), 32'h0);
        step();
        chk("t3_irq_k1", 32'(irq), 32'h1);
        ack_valid = 1'b1; ack_bits = 4'b0001;
        step();
        ack_valid = 1'b0; ack_bits = 4'h0;
        chk("t3_ack1_pending", 32'(pending), 32'hA);
        step();
        chk("t3_irq_hold", 32'(irq), 32'h1);
        ack_valid = 1'b1; ack_bits = 4'b1010;
        step();
        ack_valid = 1'b0; ack_bits = 4'h0;
        step();
        chk("t3_irq_clear", 32'(irq), 32'h0);

        // thresh=4, timeout=8: irq 8 edges after entering WAIT
        thresh = 6'd4; timeout = 16'd8;
        evt = 4'h0;
        step();
        evt = 4'b0010;
        step();
        chk("tmo_pending", 32'(pending), 32'h2);
        step();
        chk("tmo_wait_enter", 32'(irq), 32'h0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("tmo_wait", 32'(irq), 32'h0);
        end
        step();
        chk("tmo_fire", 32'(irq), 32'h1);
        ack_valid = 1'b1; ack_bits = 4'b0010;
        step();
        ack_valid = 1'b0; ack_bits = 4'h0;
        step();
        chk("tmo_clear", 32'(irq), 32'h0);

        // thresh=0 acts as 1; simultaneous rise and ack: set wins
        thresh = 6'd0; timeout = 16'd0;
        evt = 4'h0;
        step();
        evt = 4'b0001;
        step();
        step();
        chk("th0_irq", 32'(irq), 32'h1);
        evt = 4'h0;
        step();
        evt = 4'b0001; ack_valid = 1'b1; ack_bits = 4'b0001;
        step();
        ack_valid = 1'b0; ack_bits = 4'h0;
        chk("race_pending", 32'(pending), 32'h1);
        step();
        chk("race_irq", 32'(irq), 32'h1);
        ack_valid = 1'b1; ack_bits = 4'b0001;
        step();
        ack_valid = 1'b0; ack_bits = 4'h0;
        step();
        chk("race_clear", 32'(irq), 32'h0);

        // mask while asserted, then unmask
        thresh = 6'd1;
        evt = 4'h0;
        step();
        evt = 4'b0010;
        step();
        step();
        chk("mask_pre_irq", 32'(irq), 32'h1);
        mask = 4'b0010;
        step();
        chk("mask_irq", 32'(irq), 32'h0);
        chk("mask_pending", 32'(pending), 32'h2);
        mask = 4'h0;
        step();
        chk("unmask_irq", 32'(irq), 32'h1);

        // asynchronous reset mid-operation
        #2 reset_n = 1'b0;
        #1;
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_pending", 32'(pending), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
